// File: rtl/spi_xfer_ctrl_pkg.sv
`default_nettype none
//============================================================================
// spi_pkg : shared state encoding and frame constants for spi_xfer_ctrl
// Rev 1.0
//============================================================================
package spi_pkg;

  localparam int   DATA_W  = 8;
  localparam int   ADDR_W  = 7;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_GET_HDR   = 4'd1,
    ST_DECODE    = 4'd2,
    ST_RD_LOAD   = 4'd3,
    ST_RD_SHIFT  = 4'd4,
    ST_WR_SHIFT  = 4'd5,
    ST_WR_COMMIT = 4'd6,
    ST_DONE      = 4'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_xfer_ctrl_if.sv
`default_nettype none
//============================================================================
// spi_xfer_ctrl_if : strobe inputs and datapath controls of the SPI sequencer
// Rev 1.0
//============================================================================
interface spi_xfer_ctrl_if;

  logic       cs_n;
  logic       mosi;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       addr_we;
  logic       sr_load;
  logic       dm_we;
  logic       miso_en;
  logic       addr_inc;
  logic       xfer_done;
  logic       busy;
  logic [3:0] state_dbg;

  modport master (
    output cs_n, mosi, sclk_rise, sclk_fall,
    input  addr_we, sr_load, dm_we, miso_en, addr_inc, xfer_done, busy, state_dbg
  );

  modport slave (
    input  cs_n, mosi, sclk_rise, sclk_fall,
    output addr_we, sr_load, dm_we, miso_en, addr_inc, xfer_done, busy, state_dbg
  );

endinterface
`default_nettype wire

// File: rtl/spi_xfer_ctrl_bit_counter.sv
`default_nettype none
//============================================================================
// spi_bit_counter : clearable bit counter with look-ahead terminal-count hit
// Rev 1.0
//============================================================================
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // Fires on the edge that brings the count to i_tc, so the FSM can act in the same cycle
  assign o_hit     = i_en && (w_cnt_nxt == i_tc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
//============================================================================
// spi_xfer_ctrl : SPI memory-slave transaction sequencer (header, read, write)
// Optional macro SPI_BURST_EN: multi-byte streaming with address increment.
// Rev 1.0
//============================================================================
module spi_xfer_ctrl #(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           reset,
  spi_xfer_ctrl_if.slave bus
);
  import spi_pkg::*;

  state_t           r_state;
  logic             r_rw;
  logic             r_addr_we;
  logic             r_sr_load;
  logic             r_dm_we;
  logic             r_miso_en;
  logic             r_addr_inc;
  logic             r_xfer_done;
  logic             r_busy;
  logic             r_rd_wait;

  logic             w_counting;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_hit;
  logic [CNT_W-1:0] w_tc;

  assign w_counting = (r_state == ST_GET_HDR) || (r_state == ST_RD_SHIFT) ||
                      (r_state == ST_WR_SHIFT);
  assign w_cnt_en   = (r_state == ST_RD_SHIFT) ? bus.sclk_fall :
                      (w_counting ? bus.sclk_rise : 1'b0);
  assign w_tc       = (r_state == ST_GET_HDR) ? CNT_W'(ADDR_W + 1) : CNT_W'(DATA_W);
  assign w_cnt_clr  = bus.cs_n || !w_counting || w_hit;

  spi_bit_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .i_tc  (w_tc),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rw        <= 1'b0;
      r_addr_we   <= 1'b0;
      r_sr_load   <= 1'b0;
      r_dm_we     <= 1'b0;
      r_miso_en   <= 1'b0;
      r_addr_inc  <= 1'b0;
      r_xfer_done <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_wait   <= 1'b0;
    end else begin
      r_addr_we   <= 1'b0;
      r_sr_load   <= 1'b0;
      r_dm_we     <= 1'b0;
      r_addr_inc  <= 1'b0;
      r_xfer_done <= 1'b0;
      // Chip-select release wins over any concurrent SCLK edge or completion
      if ((r_state != ST_IDLE) && bus.cs_n) begin
        r_state   <= ST_IDLE;
        r_miso_en <= 1'b0;
        r_busy    <= 1'b0;
        r_rd_wait <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!bus.cs_n) begin
              r_state <= ST_GET_HDR;
              r_busy  <= 1'b1;
            end
          end
          ST_GET_HDR: begin
            if (w_hit) begin
              r_rw      <= bus.mosi;
              r_state   <= ST_DECODE;
              r_addr_we <= 1'b1;
            end
          end
          ST_DECODE: begin
            if (r_rw == RW_READ) begin
              r_state   <= ST_RD_LOAD;
              r_sr_load <= 1'b1;
            end else begin
              r_state   <= ST_WR_SHIFT;
            end
          end
          ST_RD_LOAD: begin
            // After a burst increment, hold one extra cycle so the load sees address+1
            if (r_rd_wait) begin
              r_rd_wait <= 1'b0;
              r_sr_load <= 1'b1;
            end else begin
              r_state   <= ST_RD_SHIFT;
              r_miso_en <= 1'b1;
            end
          end
          ST_RD_SHIFT: begin
            if (w_hit) begin
              r_xfer_done <= 1'b1;
              r_miso_en   <= 1'b0;
`ifdef SPI_BURST_EN
              r_state     <= ST_RD_LOAD;
              r_addr_inc  <= 1'b1;
              r_rd_wait   <= 1'b1;
`else
              r_state     <= ST_DONE;
`endif
            end
          end
          ST_WR_SHIFT: begin
            if (w_hit) begin
              r_state     <= ST_WR_COMMIT;
              r_dm_we     <= 1'b1;
              r_xfer_done <= 1'b1;
`ifdef SPI_BURST_EN
              r_addr_inc  <= 1'b1;
`endif
            end
          end
          ST_WR_COMMIT: begin
`ifdef SPI_BURST_EN
            r_state <= ST_WR_SHIFT;
`else
            r_state <= ST_DONE;
`endif
          end
          ST_DONE: begin
            r_state <= ST_DONE;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_miso_en <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.addr_we   = r_addr_we;
  assign bus.sr_load   = r_sr_load;
  assign bus.dm_we     = r_dm_we;
  assign bus.miso_en   = r_miso_en;
  assign bus.addr_inc  = r_addr_inc;
  assign bus.xfer_done = r_xfer_done;
  assign bus.busy      = r_busy;
  assign bus.state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
//============================================================================
// tb_spi_xfer_ctrl : scoreboard bench for spi_xfer_ctrl (SPI_BURST_EN aware)
// Rev 1.0
//============================================================================
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int EV_ADDR_WE   = 1;
  localparam int EV_SR_LOAD   = 2;
  localparam int EV_DM_WE     = 3;
  localparam int EV_XFER_DONE = 4;
  localparam int EV_ADDR_INC  = 5;

`ifdef SPI_BURST_EN
  localparam logic [3:0] RD_END_ST   = 4'd4;
  localparam logic       RD_END_MISO = 1'b1;
  localparam logic [3:0] WR_END_ST   = 4'd5;
`else
  localparam logic [3:0] RD_END_ST   = 4'd7;
  localparam logic       RD_END_MISO = 1'b0;
  localparam logic [3:0] WR_END_ST   = 4'd7;
`endif

  logic clk;
  logic reset;
  spi_xfer_ctrl_if bus_if ();

  spi_xfer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int       n_chk;
  int       n_err;
  int       cyc;
  int       hdr_cyc;
  int       exp_sr_cyc;
  logic     sr_exp_valid;
  logic     miso_seen;
  logic [6:0] hdr_addr;
  logic [6:0] lat_addr;
  int       exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic evt(input int kind);
    int e;
    if (exp_q.size() == 0) begin
      chk("unexpected_evt", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk("evt_order", kind, e);
    end
  endtask

  // Scoreboard side: every DUT pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.miso_en) miso_seen = 1'b1;
      if (bus_if.addr_we) begin
        evt(EV_ADDR_WE);
        chk("addr_we_lat", cyc - hdr_cyc, 1);
        lat_addr = hdr_addr;
      end
      if (bus_if.sr_load) begin
        evt(EV_SR_LOAD);
        if (sr_exp_valid) chk("sr_load_lat", cyc, exp_sr_cyc);
        sr_exp_valid = 1'b0;
      end
      if (bus_if.dm_we)     evt(EV_DM_WE);
      if (bus_if.xfer_done) evt(EV_XFER_DONE);
      if (bus_if.addr_inc) begin
        evt(EV_ADDR_INC);
        lat_addr = lat_addr + 7'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rise(input logic b);
    bus_if.mosi      = b;
    bus_if.sclk_rise = 1'b1;
    tick();
    bus_if.sclk_rise = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_fall();
    bus_if.sclk_fall = 1'b1;
    tick();
    bus_if.sclk_fall = 1'b0;
    tick();
    tick();
  endtask

  // guard=1 holds the 8th rise one extra cycle so a second rise lands in DECODE
  task automatic send_hdr(input logic [6:0] a, input logic rw, input logic guard);
    for (int i = 6; i >= 0; i--) begin
      pulse_rise(a[i]);
      pulse_fall();
    end
    hdr_addr = a;
    exp_q.push_back(EV_ADDR_WE);
    if (rw) begin
      exp_q.push_back(EV_SR_LOAD);
      exp_sr_cyc   = cyc + 2;
      sr_exp_valid = 1'b1;
    end
    hdr_cyc = cyc;
    if (guard) begin
      bus_if.mosi      = rw;
      bus_if.sclk_rise = 1'b1;
      tick();
      tick();
      bus_if.sclk_rise = 1'b0;
      tick();
    end else begin
      pulse_rise(rw);
    end
    tick();
    tick();
  endtask

  task automatic push_rd_end();
    exp_q.push_back(EV_XFER_DONE);
`ifdef SPI_BURST_EN
    exp_q.push_back(EV_ADDR_INC);
    exp_q.push_back(EV_SR_LOAD);
`endif
  endtask

  task automatic read_byte();
    for (int i = 0; i < DATA_W; i++) begin
      chk("miso_en_shift", bus_if.miso_en, 1);
      if (i == DATA_W - 1) push_rd_end();
      pulse_fall();
      if (i != DATA_W - 1) pulse_rise(1'b0);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      pulse_fall();
      if (i == 0) begin
        exp_q.push_back(EV_DM_WE);
        exp_q.push_back(EV_XFER_DONE);
`ifdef SPI_BURST_EN
        exp_q.push_back(EV_ADDR_INC);
`endif
      end
      pulse_rise(d[i]);
    end
  endtask

  task automatic end_frame();
    bus_if.cs_n = 1'b1;
    tick();
    chk("idle_state", bus_if.state_dbg, ST_IDLE);
    chk("idle_busy", bus_if.busy, 0);
    chk("idle_miso_en", bus_if.miso_en, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; hdr_cyc = 0; exp_sr_cyc = 0;
    sr_exp_valid = 1'b0; miso_seen = 1'b0; hdr_addr = '0; lat_addr = '0;
    reset = 1'b1;
    bus_if.cs_n = 1'b1; bus_if.mosi = 1'b0;
    bus_if.sclk_rise = 1'b0; bus_if.sclk_fall = 1'b0;
    tick(); tick();
    chk("rst_state", bus_if.state_dbg, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_addr_we", bus_if.addr_we, 0);
    chk("rst_sr_load", bus_if.sr_load, 0);
    chk("rst_dm_we", bus_if.dm_we, 0);
    chk("rst_miso_en", bus_if.miso_en, 0);
    chk("rst_addr_inc", bus_if.addr_inc, 0);
    chk("rst_xfer_done", bus_if.xfer_done, 0);
    reset = 1'b0;
    tick();

    // Single-byte write to 0x2A
    miso_seen = 1'b0;
    bus_if.cs_n = 1'b0;
    tick();
    chk("cs_busy_lat", bus_if.busy, 1);
    chk("cs_state", bus_if.state_dbg, ST_GET_HDR);
    send_hdr(7'h2A, 1'b0, 1'b0);
    chk("wr_shift_state", bus_if.state_dbg, ST_WR_SHIFT);
    write_byte(8'hC3);
    chk("wr_end_state", bus_if.state_dbg, WR_END_ST);
    tick(); tick(); tick(); tick();
    end_frame();
    chk("wr_miso_never", miso_seen, 0);
    chk("wr_q_empty", exp_q.size(), 0);

    // Single-byte read from 0x2A
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h2A, 1'b1, 1'b0);
    chk("rd_shift_state", bus_if.state_dbg, ST_RD_SHIFT);
    read_byte();
    chk("rd_end_state", bus_if.state_dbg, RD_END_ST);
    chk("rd_end_miso", bus_if.miso_en, RD_END_MISO);
    end_frame();
    chk("rd_q_empty", exp_q.size(), 0);

    // Write aborted after 5 data rises: no dm_we may follow
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h15, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pulse_fall();
      pulse_rise(1'b1);
    end
    end_frame();
    tick(); tick(); tick(); tick();
    chk("abort_q_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a read
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h33, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_fall();
      pulse_rise(1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", bus_if.state_dbg, 0);
    chk("arst_busy", bus_if.busy, 0);
    chk("arst_miso_en", bus_if.miso_en, 0);
    chk("arst_xfer_done", bus_if.xfer_done, 0);
    bus_if.cs_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h2A, 1'b0, 1'b0);
    write_byte(8'h5A);
    chk("post_rst_wr_state", bus_if.state_dbg, WR_END_ST);
    end_frame();
    chk("post_rst_q_empty", exp_q.size(), 0);

    // Rise during DECODE is ignored: dm_we still needs 8 data rises
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h0F, 1'b0, 1'b1);
    write_byte(8'hA5);
    chk("guard_wr_state", bus_if.state_dbg, WR_END_ST);
    end_frame();
    chk("guard_q_empty", exp_q.size(), 0);

`ifdef SPI_BURST_EN
    // Two-byte burst read across the address wrap
    bus_if.cs_n = 1'b0;
    tick();
    send_hdr(7'h7F, 1'b1, 1'b0);
    chk("burst_lat_addr0", lat_addr, 7'h7F);
    read_byte();
    chk("burst_wrap_addr", lat_addr, 7'h00);
    chk("burst_b2_state", bus_if.state_dbg, ST_RD_SHIFT);
    read_byte();
    chk("burst_addr_b2", lat_addr, 7'h01);
    end_frame();
    chk("burst_q_empty", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
